regfile_wb_sched: RTL and testbench

Write-back scheduler and load scoreboard in front of the single write port of the 32x32 register file.
- Arbitrates that port between the execute-stage result path (EX) and the load unit (LD) using valid/ready handshakes and round-robin priority.
- Drives a registered write command, giving one cycle of latency.
- Tracks destination registers of issued loads that have not yet been written, and raises a stall to issue on RAW/WAW hazards.

---
 rtl/regfile_wb_sched.sv | 129 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single register-file write port: round-robin EX/LD
// arbitration, registered write command, and a load scoreboard with issue stall.
// Optional build macro REGFILE_WB_STATS_EN adds a saturating conflict counter port.
module regfile_wb_sched #(
  parameter int XLEN    = 32,
  parameter int RR_INIT = 0
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            issue_valid_i,
  input  logic            issue_is_load_i,
  input  logic [4:0]      issue_rd_ptr_i,
  input  logic [4:0]      issue_rs1_ptr_i,
  input  logic [4:0]      issue_rs2_ptr_i,
  output logic            issue_stall_o,
  input  logic            ex_valid_i,
  input  logic [4:0]      ex_rd_ptr_i,
  input  logic [XLEN-1:0] ex_rd_i,
  output logic            ex_ready_o,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_rd_ptr_i,
  input  logic [XLEN-1:0] ld_rd_i,
  output logic            ld_ready_o,
  output logic            reg_write_en_o,
  output logic [4:0]      rd_ptr_o,
  output logic [XLEN-1:0] rd_o,
`ifdef REGFILE_WB_STATS_EN
  output logic [15:0]     conflict_cnt_o,
`endif
  output logic [31:0]     pending_o
);

  logic            rr_q;        // 1 favours EX, 0 favours LD
  logic            conflict;
  logic            grant;
  logic            grant_ld;
  logic [4:0]      grant_ptr;
  logic [XLEN-1:0] grant_data;
  logic            wr_from_ld_q;
  logic            issue_fire;
  logic [31:0]     pending_q;
  logic [31:0]     pending_d;

  // Ready depends only on the valids and the RR pointer, never on ready itself.
  assign conflict   = ex_valid_i & ld_valid_i;
  assign ex_ready_o = ex_valid_i & (~ld_valid_i | rr_q);
  assign ld_ready_o = ld_valid_i & (~ex_valid_i | ~rr_q);
  assign grant      = ex_ready_o | ld_ready_o;
  assign grant_ld   = ld_ready_o;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_ptr  = ex_rd_ptr_i;
    grant_data = ex_rd_i;
    if (grant_ld) begin
      grant_ptr  = ld_rd_ptr_i;
      grant_data = ld_rd_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q <= (RR_INIT != 0);
    end else if (conflict) begin
      rr_q <= ~rr_q;
    end
  end

  // Address/data hold their last value when no write is issued.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      reg_write_en_o <= 1'b0;
      rd_ptr_o       <= '0;
      rd_o           <= '0;
      wr_from_ld_q   <= 1'b0;
    end else begin
      reg_write_en_o <= grant;
      if (grant) begin
        rd_ptr_o     <= grant_ptr;
        rd_o         <= grant_data;
        wr_from_ld_q <= grant_ld;
      end
    end
  end

  assign issue_stall_o = issue_valid_i &
                         (pending_q[issue_rs1_ptr_i] | pending_q[issue_rs2_ptr_i] |
                          pending_q[issue_rd_ptr_i]);
  assign issue_fire    = issue_valid_i & ~issue_stall_o;

  // Clear from a completing LD write first, then set from a new load, so set wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_write_en_o && wr_from_ld_q) begin
      pending_d[rd_ptr_o] = 1'b0;
    end
    if (issue_fire && issue_is_load_i && (issue_rd_ptr_i != 5'd0)) begin
      pending_d[issue_rd_ptr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is cleared by reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

`ifdef REGFILE_WB_STATS_EN
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      conflict_cnt_q <= '0;
    end else if (conflict && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected writes are queued when a grant is
// driven and popped when the registered write command appears.
module tb_regfile_wb_sched;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      ptr;
    logic [XLEN-1:0] data;
  } wr_t;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            issue_valid_i, issue_is_load_i;
  logic [4:0]      issue_rd_ptr_i, issue_rs1_ptr_i, issue_rs2_ptr_i;
  logic            issue_stall_o;
  logic            ex_valid_i, ld_valid_i;
  logic [4:0]      ex_rd_ptr_i, ld_rd_ptr_i;
  logic [XLEN-1:0] ex_rd_i, ld_rd_i;
  logic            ex_ready_o, ld_ready_o;
  logic            reg_write_en_o;
  logic [4:0]      rd_ptr_o;
  logic [XLEN-1:0] rd_o;
  logic [31:0]     pending_o;
`ifdef REGFILE_WB_STATS_EN
  logic [15:0]     conflict_cnt_o;
`endif

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];

  regfile_wb_sched #(.XLEN(XLEN), .RR_INIT(0)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .issue_valid_i   (issue_valid_i),
    .issue_is_load_i (issue_is_load_i),
    .issue_rd_ptr_i  (issue_rd_ptr_i),
    .issue_rs1_ptr_i (issue_rs1_ptr_i),
    .issue_rs2_ptr_i (issue_rs2_ptr_i),
    .issue_stall_o   (issue_stall_o),
    .ex_valid_i      (ex_valid_i),
    .ex_rd_ptr_i     (ex_rd_ptr_i),
    .ex_rd_i         (ex_rd_i),
    .ex_ready_o      (ex_ready_o),
    .ld_valid_i      (ld_valid_i),
    .ld_rd_ptr_i     (ld_rd_ptr_i),
    .ld_rd_i         (ld_rd_i),
    .ld_ready_o      (ld_ready_o),
    .reg_write_en_o  (reg_write_en_o),
    .rd_ptr_o        (rd_ptr_o),
    .rd_o            (rd_o),
`ifdef REGFILE_WB_STATS_EN
    .conflict_cnt_o  (conflict_cnt_o),
`endif
    .pending_o       (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and compare the write command against the scoreboard.
  task automatic cycle(input string tag);
    wr_t e;
    @(posedge clk_i);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_we"},   {31'd0, reg_write_en_o}, 32'd1);
      check({tag, "_ptr"},  {27'd0, rd_ptr_o}, {27'd0, e.ptr});
      check({tag, "_data"}, rd_o, e.data);
    end else begin
      check({tag, "_idle"}, {31'd0, reg_write_en_o}, 32'd0);
    end
  endtask

  initial begin
    rstn_i = 1'b0;
    issue_valid_i = 0; issue_is_load_i = 0;
    issue_rd_ptr_i = 0; issue_rs1_ptr_i = 0; issue_rs2_ptr_i = 0;
    ex_valid_i = 0; ex_rd_ptr_i = 0; ex_rd_i = 0;
    ld_valid_i = 0; ld_rd_ptr_i = 0; ld_rd_i = 0;

    // Reset and idle
    #3;
    check("rst_we",      {31'd0, reg_write_en_o}, 32'd0);
    check("rst_ptr",     {27'd0, rd_ptr_o}, 32'd0);
    check("rst_data",    rd_o, 32'd0);
    check("rst_pending", pending_o, 32'd0);
    check("idle_ready",  {30'd0, ex_ready_o, ld_ready_o}, 32'd0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    cycle("idle");

    // EX only
    ex_valid_i = 1; ex_rd_ptr_i = 5; ex_rd_i = 32'hDEADBEEF;
    #1;
    check("ex_only_ready", {30'd0, ex_ready_o, ld_ready_o}, 32'b10);
    exp_q.push_back('{ptr: 5'd5, data: 32'hDEADBEEF});
    cycle("ex_only");
    ex_valid_i = 0;
    cycle("ex_only_after");
    check("hold_ptr",  {27'd0, rd_ptr_o}, 32'd5);
    check("hold_data", rd_o, 32'hDEADBEEF);

    // Conflict: LD favoured first, then EX
    ex_valid_i = 1; ex_rd_ptr_i = 3; ex_rd_i = 32'h3333_0003;
    ld_valid_i = 1; ld_rd_ptr_i = 4; ld_rd_i = 32'h4444_0004;
    #1;
    check("conf0_ready", {30'd0, ex_ready_o, ld_ready_o}, 32'b01);
    exp_q.push_back('{ptr: 5'd4, data: 32'h4444_0004});
    cycle("conf0");
    check("conf1_ready", {30'd0, ex_ready_o, ld_ready_o}, 32'b10);
    exp_q.push_back('{ptr: 5'd3, data: 32'h3333_0003});
    cycle("conf1");
    ex_valid_i = 0; ld_valid_i = 0;
    check("conf_pending", pending_o, 32'd0);

    // Load RAW
    issue_valid_i = 1; issue_is_load_i = 1; issue_rd_ptr_i = 7;
    #1;
    check("ld7_nostall", {31'd0, issue_stall_o}, 32'd0);
    cycle("ld7_issue");
    check("ld7_pending", pending_o, 32'h80);
    issue_is_load_i = 0; issue_rd_ptr_i = 1; issue_rs1_ptr_i = 7;
    #1;
    check("raw_stall", {31'd0, issue_stall_o}, 32'd1);
    ld_valid_i = 1; ld_rd_ptr_i = 7; ld_rd_i = 32'h0000_0077;
    #1;
    check("ld7_ready", {30'd0, ex_ready_o, ld_ready_o}, 32'b01);
    exp_q.push_back('{ptr: 5'd7, data: 32'h0000_0077});
    cycle("ld7_wb");
    ld_valid_i = 0;
    #1;
    check("raw_stall_wbcycle", {31'd0, issue_stall_o}, 32'd1);
    check("pending_wbcycle", pending_o, 32'h80);
    cycle("ld7_after");
    check("raw_stall_drop", {31'd0, issue_stall_o}, 32'd0);
    check("ld7_cleared", pending_o, 32'd0);
    issue_valid_i = 0; issue_rs1_ptr_i = 0;

    // Load to x0 never becomes pending
    issue_valid_i = 1; issue_is_load_i = 1; issue_rd_ptr_i = 0;
    cycle("ld0_issue");
    check("ld0_pending", pending_o, 32'd0);

    // WAW on x9, then clear and set of bit 9 at the same edge
    issue_rd_ptr_i = 9;
    cycle("ld9_issue");
    check("ld9_pending", pending_o, 32'h200);
    #1;
    check("waw_stall", {31'd0, issue_stall_o}, 32'd1);
    ld_valid_i = 1; ld_rd_ptr_i = 9; ld_rd_i = 32'h0000_0099;
    exp_q.push_back('{ptr: 5'd9, data: 32'h0000_0099});
    cycle("ld9_wb");
    check("waw_stall_wbcycle", {31'd0, issue_stall_o}, 32'd1);
    ld_rd_i = 32'h0000_009B;
    exp_q.push_back('{ptr: 5'd9, data: 32'h0000_009B});
    cycle("ld9_wb2");
    check("ld9_cleared", pending_o, 32'd0);
    check("ld9_reissue_nostall", {31'd0, issue_stall_o}, 32'd0);
    ld_valid_i = 0;
    cycle("ld9_setclr");
    check("set_wins", pending_o, 32'h200);
    issue_valid_i = 0; issue_is_load_i = 0; issue_rd_ptr_i = 0;

    // Async reset mid-operation with a write in flight and RR moved to EX
    ex_valid_i = 1; ex_rd_ptr_i = 12; ex_rd_i = 32'h0000_000C;
    ld_valid_i = 1; ld_rd_ptr_i = 13; ld_rd_i = 32'h0000_000D;
    @(posedge clk_i); #1;
    check("inflight_we", {31'd0, reg_write_en_o}, 32'd1);
    ex_valid_i = 0; ld_valid_i = 0;
    #2;
    rstn_i = 1'b0;
    #1;
    check("async_we",      {31'd0, reg_write_en_o}, 32'd0);
    check("async_ptr",     {27'd0, rd_ptr_o}, 32'd0);
    check("async_data",    rd_o, 32'd0);
    check("async_pending", pending_o, 32'd0);
`ifdef REGFILE_WB_STATS_EN
    check("async_cnt", {16'd0, conflict_cnt_o}, 32'd0);
`endif
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    ex_valid_i = 1; ld_valid_i = 1;
    #1;
    check("rr_after_reset", {30'd0, ex_ready_o, ld_ready_o}, 32'b01);

`ifdef REGFILE_WB_STATS_EN
    repeat (3) @(posedge clk_i);
    #1;
    check("cnt_three", {16'd0, conflict_cnt_o}, 32'd3);
    repeat (32'h10000) @(posedge clk_i);
    #1;
    check("cnt_saturate", {16'd0, conflict_cnt_o}, 32'h0000FFFF);
`endif
    ex_valid_i = 0; ld_valid_i = 0;
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
